sha2_stream_core: RTL and testbench
===================================

Name: sha2_stream_core

Overview:
Parametrised successor to the single-block sha256 core. It is an iterative SHA-256/SHA-224 compression engine with configurable rounds per cycle and multi-block chaining, so messages longer than one 512-bit block can be hashed. It uses a valid/ready handshake on both input and output. It sits between the padding/block formatter and the RIPEMD-160 stage of the Hash160 datapath.

Parameters:
ROUNDS_PER_CYCLE, 1, compression rounds unrolled per clock; legal values 1, 2, 4, 8; any other value is an elaboration error.
SUPPORT_224, 1, when 0, mode_224 is ignored and the block is tied to SHA-256.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_block and its flags are valid
in_ready  output  1  core can accept a block
in_block  input  512  message block; W0 = in_block[511:480], W15 = in_block[31:0]
in_first  input  1  block starts a new message; load IV
in_last  input  1  block ends the message; publish digest
mode_224  input  1  1 = SHA-224; sampled only when in_first=1
out_valid  output  1  digest valid
out_ready  input  1  consumer accepts digest
digest  output  256  H0 in [255:224] ... H7 in [31:0]; SHA-224 mode gives H0..H6 in [255:32] and [31:0]=0
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, in_ready=1, out_valid=0, digest=0, busy=0.
  - Chaining registers load the SHA-256 IV; latched mode = 256.
  - Reset mid-operation aborts the current block and message; no partial digest is ever presented.
- States: IDLE, ROUND, FINAL, HOLD. in_ready = (state==IDLE).
- IDLE:
  - Accept on a rising edge with in_valid && in_ready.
  - Capture the block into a 16x32 schedule shift register.
  - If in_first=1: set the working variables a..h and the chaining H from the IV for mode_224 (SHA-256 IV if SUPPORT_224=0), and latch the mode.
  - If in_first=0: set a..h from the current chaining H.
  - Latch in_last. Go to ROUND with round counter=0.
- ROUND:
  - Each cycle applies ROUNDS_PER_CYCLE rounds t..t+R-1 using K[t] and W[t].
  - The schedule shifts by R words; new words follow W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32.
  - Counter advances by R. After 64/R cycles, go to FINAL.
- FINAL (1 cycle): H[i] <= H[i] + working[i], mod 2^32.
  - If last: load digest, set out_valid, go to HOLD.
  - Else: go to IDLE with the chaining H retained.
- HOLD:
  - digest and out_valid are stable while out_ready=0.
  - On out_valid && out_ready: out_valid falls next edge, go to IDLE.
  - in_ready stays low throughout HOLD.
- Latency: out_valid rises on the edge 64/R+1 cycles after the accepting edge (R=1: 65; R=4: 17).
- Throughput: block-to-block ingest interval is 64/R+2 cycles for non-last blocks.
- Boundary cases:
  - in_first=1 with in_last=1: single-block message.
  - in_first=0 as the first block after reset: uses the reset IV (SHA-256), giving identical results.
  - mode_224 with in_first=0 is ignored.
  - in_valid asserted outside IDLE is not accepted; the driver must hold it stable until accepted.
- All arithmetic is 32-bit modulo-2^32 addition; rotations and shifts follow FIPS 180-4.

Decomposition:
- Package sha2_pkg:
  - K[0:63] constants, IV256[8], IV224[8].
  - Functions Ch, Maj, Sigma0, Sigma1, sigma0, sigma1.
  - State enum typedef, word typedef (32-bit).
- Sub-module sha2_round: one combinational round taking a..h, K, W and producing the next a..h. It is instantiated ROUNDS_PER_CYCLE times in a chain via generate.

Test Plan:
- "abc" single block (in_block = 0x61626380, then zeros, then length 0x18 in [63:0]), first=last=1, R=1 -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; out_valid exactly 65 cycles after acceptance.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first=1,last=0, then first=0,last=1) -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; no out_valid after block 1.
- mode_224=1 "abc" -> digest[255:32] = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, digest[31:0]=0.
- Repeat the "abc" case with R=2, 4 and 8 -> same digest; latency 33, 17 and 9 cycles respectively.
- out_ready held low 10 cycles after out_valid -> digest stable, in_ready=0, second in_valid not accepted; out_ready=1 -> out_valid low next edge, in_ready=1.
- rst_n pulsed low at round 30 of the "abc" case -> out_valid=0 and in_ready=1 immediately; a fresh "abc" then yields ba7816bf...f20015ad.

Source files
------------

// File: rtl/sha2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha2_pkg
// Brief    : SHA-224/256 constants, round helper functions and shared types
// Revision : 1.0
// ============================================================================
package sha2_pkg;

  typedef logic [31:0] word_t;

  // Index 0 is the most significant word, so a 512-bit block maps straight in as W0..W15.
  typedef logic [0:15][31:0] sched_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } work_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam word_t c_k [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam work_t c_iv256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam work_t c_iv224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic work_t add_work(input work_t x, input work_t y);
    work_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha2_round.sv
`default_nettype none
// ============================================================================
// Module   : sha2_round
// Brief    : one combinational SHA-2 compression round
// Revision : 1.0
// ============================================================================
module sha2_round
  import sha2_pkg::*;
(
  input  work_t i_state,
  input  word_t i_k,
  input  word_t i_w,
  output work_t o_state
);

  word_t w_t1;
  word_t w_t2;

  assign w_t1 = i_state.h + big_sigma1(i_state.e) + ch(i_state.e, i_state.f, i_state.g) + i_k + i_w;
  assign w_t2 = big_sigma0(i_state.a) + maj(i_state.a, i_state.b, i_state.c);

  assign o_state.a = w_t1 + w_t2;
  assign o_state.b = i_state.a;
  assign o_state.c = i_state.b;
  assign o_state.d = i_state.c;
  assign o_state.e = i_state.d + w_t1;
  assign o_state.f = i_state.e;
  assign o_state.g = i_state.f;
  assign o_state.h = i_state.g;

endmodule
`default_nettype wire

// File: rtl/sha2_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : sha2_stream_core
// Brief    : iterative multi-block SHA-256/SHA-224 engine, R rounds per clock
// Revision : 1.0
// ============================================================================
module sha2_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SUPPORT_224      = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         mode_224,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         busy
);
  import sha2_pkg::*;

  localparam logic [5:0] c_step     = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] c_last_cnt = 6'(64 - ROUNDS_PER_CYCLE);

  generate
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rounds
      $error("sha2_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  state_t     r_state;
  work_t      r_work;
  work_t      r_h;
  sched_t     r_w;
  logic [5:0] r_cnt;
  logic       r_last;
  logic       r_mode_224;

  logic  w_mode_in;
  work_t w_iv;
  work_t w_round_out;
  work_t w_h_sum;

  assign w_mode_in = SUPPORT_224 && mode_224;
  assign w_iv      = w_mode_in ? c_iv224 : c_iv256;
  assign w_h_sum   = add_work(r_h, r_work);
  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);

  // Extends the schedule by R words, then drops the R words consumed this cycle.
  function automatic sched_t next_sched(input sched_t w);
    word_t  ext [16 + ROUNDS_PER_CYCLE];
    sched_t nxt;
    for (int i = 0; i < 16; i++) ext[i] = w[i];
    for (int i = 16; i < 16 + ROUNDS_PER_CYCLE; i++)
      ext[i] = small_sigma1(ext[i-2]) + ext[i-7] + small_sigma0(ext[i-15]) + ext[i-16];
    for (int i = 0; i < 16; i++) nxt[i] = ext[i + ROUNDS_PER_CYCLE];
    return nxt;
  endfunction

  generate
    for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
      work_t w_in;
      work_t w_out;
      word_t w_k;
      if (gi == 0) begin : g_head
        assign w_in = r_work;
      end else begin : g_link
        assign w_in = g_round[gi-1].w_out;
      end
      assign w_k = c_k[r_cnt + 6'(gi)];
      sha2_round u_round (
        .i_state (w_in),
        .i_k     (w_k),
        .i_w     (r_w[gi]),
        .o_state (w_out)
      );
    end
  endgenerate

  assign w_round_out = g_round[ROUNDS_PER_CYCLE-1].w_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_work     <= '0;
      r_h        <= c_iv256;
      r_w        <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_mode_224 <= 1'b0;
      digest     <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_w <= in_block;
            if (in_first) begin
              r_work     <= w_iv;
              r_h        <= w_iv;
              r_mode_224 <= w_mode_in;
            end else begin
              r_work <= r_h;
            end
            r_last  <= in_last;
            r_cnt   <= '0;
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_work <= w_round_out;
          r_w    <= next_sched(r_w);
          r_cnt  <= r_cnt + c_step;
          if (r_cnt == c_last_cnt) r_state <= ST_FINAL;
        end
        ST_FINAL: begin
          r_h <= w_h_sum;
          if (r_last) begin
            // SHA-224 publishes H0..H6 only; the low word is forced to zero.
            digest    <= r_mode_224 ? {w_h_sum[255:32], 32'h0} : w_h_sum;
            out_valid <= 1'b1;
            r_state   <= ST_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha2_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha2_stream_core
// Brief    : directed-vector bench for sha2_stream_core at R = 1, 2, 4, 8
// Revision : 1.0
// ============================================================================
module tb_sha2_stream_core;

  localparam logic [511:0] c_blk_abc = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] c_blk_two1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] c_blk_two2 = {448'h0, 64'h1c0};
  localparam logic [255:0] c_abc_256 =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] c_two_256 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] c_abc_224 =
    {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid, in_first, in_last, mode_224, out_ready;
  logic [3:0]   in_ready, out_valid, busy;
  logic [511:0] in_block [4];
  logic [255:0] digest [4];
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      sha2_stream_core #(.ROUNDS_PER_CYCLE(1 << gi), .SUPPORT_224(1'b1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .in_block  (in_block[gi]),
        .in_first  (in_first[gi]),
        .in_last   (in_last[gi]),
        .mode_224  (mode_224[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .digest    (digest[gi]),
        .busy      (busy[gi])
      );
    end
  endgenerate

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents a block and returns just after the edge that accepted it.
  task automatic send_block(input int idx, input logic [511:0] blk, input logic first,
                            input logic last, input logic mode);
    int n = 0;
    in_block[idx] = blk;
    in_first[idx] = first;
    in_last[idx]  = last;
    mode_224[idx] = mode;
    in_valid[idx] = 1'b1;
    while (!in_ready[idx] && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready[idx]) begin
      total++; bad++;
      $display("FAIL accept_timeout dut%0d: in_ready=%b required=1", idx, in_ready[idx]);
    end
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
  endtask

  // Counts edges from acceptance until out_valid is seen; -1 on timeout.
  task automatic wait_out(input int idx, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid[idx] && lat < 300);
    if (!out_valid[idx]) begin
      lat = -1;
      total++; bad++;
      $display("FAIL out_timeout dut%0d: out_valid=%b required=1", idx, out_valid[idx]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0; in_first = '0; in_last = '0; mode_224 = '0; out_ready = '1;
    for (int i = 0; i < 4; i++) in_block[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (in_ready[i] !== 1'b1) begin bad++; $display("FAIL reset_in_ready dut%0d: got %b want 1", i, in_ready[i]); end
      total++; if (out_valid[i] !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut%0d: got %b want 0", i, out_valid[i]); end
      total++; if (busy[i] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d: got %b want 0", i, busy[i]); end
      total++; if (digest[i] !== 256'h0) begin bad++; $display("FAIL reset_digest dut%0d: got %h want 0", i, digest[i]); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // in_first=0 straight after reset must chain from the SHA-256 IV; mode_224 is ignored.
  task automatic test_first0_after_reset();
    int lat;
    send_block(0, c_blk_abc, 1'b0, 1'b1, 1'b1);
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL busy_after_accept: got %b want 1", busy[0]); end
    wait_out(0, lat);
    total++; if (digest[0] !== c_abc_256) begin bad++; $display("FAIL first0_digest: got %h want %h", digest[0], c_abc_256); end
    @(posedge clk); #1;
    total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL first0_out_drop: got %b want 0", out_valid[0]); end
  endtask

  task automatic test_abc_r1();
    int lat;
    send_block(0, c_blk_abc, 1'b1, 1'b1, 1'b0);
    wait_out(0, lat);
    total++; if (lat !== 65) begin bad++; $display("FAIL abc_r1_latency: got %0d want 65", lat); end
    total++; if (digest[0] !== c_abc_256) begin bad++; $display("FAIL abc_r1_digest: got %h want %h", digest[0], c_abc_256); end
    @(posedge clk); #1;
  endtask

  task automatic test_two_block();
    int lat;
    int n = 0;
    bit seen = 1'b0;
    send_block(0, c_blk_two1, 1'b1, 1'b0, 1'b0);
    do begin
      @(posedge clk); #1; n++;
      if (out_valid[0]) seen = 1'b1;
    end while (!in_ready[0] && n < 300);
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL two_block_no_out: got out_valid seen=%b want 0", seen); end
    total++; if (n !== 65) begin bad++; $display("FAIL two_block_reready: got %0d want 65", n); end
    send_block(0, c_blk_two2, 1'b0, 1'b1, 1'b0);
    wait_out(0, lat);
    total++; if (digest[0] !== c_two_256) begin bad++; $display("FAIL two_block_digest: got %h want %h", digest[0], c_two_256); end
    @(posedge clk); #1;
  endtask

  task automatic test_sha224();
    int lat;
    send_block(0, c_blk_abc, 1'b1, 1'b1, 1'b1);
    wait_out(0, lat);
    total++; if (digest[0] !== c_abc_224) begin bad++; $display("FAIL sha224_digest: got %h want %h", digest[0], c_abc_224); end
    @(posedge clk); #1;
  endtask

  task automatic test_rounds();
    int lat;
    int exp_lat;
    for (int i = 1; i < 4; i++) begin
      exp_lat = 64 / (1 << i) + 1;
      send_block(i, c_blk_abc, 1'b1, 1'b1, 1'b0);
      wait_out(i, lat);
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL rounds_latency dut%0d: got %0d want %0d", i, lat, exp_lat); end
      total++; if (digest[i] !== c_abc_256) begin bad++; $display("FAIL rounds_digest dut%0d: got %h want %h", i, digest[i], c_abc_256); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    int lat;
    out_ready[3] = 1'b0;
    send_block(3, c_blk_abc, 1'b1, 1'b1, 1'b0);
    wait_out(3, lat);
    in_block[3] = c_blk_two1; in_first[3] = 1'b1; in_last[3] = 1'b1; in_valid[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid[3] !== 1'b1) begin bad++; $display("FAIL hold_out_valid cyc%0d: got %b want 1", i, out_valid[3]); end
      total++; if (digest[3] !== c_abc_256) begin bad++; $display("FAIL hold_digest cyc%0d: got %h want %h", i, digest[3], c_abc_256); end
      total++; if (in_ready[3] !== 1'b0) begin bad++; $display("FAIL hold_in_ready cyc%0d: got %b want 0", i, in_ready[3]); end
    end
    out_ready[3] = 1'b1;
    @(posedge clk); #1;
    in_valid[3] = 1'b0;
    total++; if (out_valid[3] !== 1'b0) begin bad++; $display("FAIL hold_release_out: got %b want 0", out_valid[3]); end
    total++; if (in_ready[3] !== 1'b1) begin bad++; $display("FAIL hold_release_ready: got %b want 1", in_ready[3]); end
    @(posedge clk); #1;
    total++; if (busy[3] !== 1'b0) begin bad++; $display("FAIL hold_no_accept: busy got %b want 0", busy[3]); end
  endtask

  task automatic test_reset_mid();
    int lat;
    send_block(0, c_blk_abc, 1'b1, 1'b1, 1'b0);
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL midreset_out_valid: got %b want 0", out_valid[0]); end
    total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL midreset_in_ready: got %b want 1", in_ready[0]); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy[0]); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_block(0, c_blk_abc, 1'b1, 1'b1, 1'b0);
    wait_out(0, lat);
    total++; if (lat !== 65) begin bad++; $display("FAIL midreset_latency: got %0d want 65", lat); end
    total++; if (digest[0] !== c_abc_256) begin bad++; $display("FAIL midreset_digest: got %h want %h", digest[0], c_abc_256); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_first0_after_reset();
    test_abc_r1();
    test_two_block();
    test_sha224();
    test_rounds();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
